// File: rtl/xbar_grant_scheduler.sv
// Per-output grant scheduler for the packet crossbar: priority arbitration with round-robin tie-break,
// connection held until the last beat. Define XBAR_SCHED_AGING_EN to enable starvation aging.
module xbar_grant_scheduler #(
    parameter int NUM_INPUTS  = 8,
    parameter int NUM_OUTPUTS = 8,
    parameter int IN_W        = $clog2(NUM_INPUTS),
    parameter int DEST_W      = $clog2(NUM_OUTPUTS),
    parameter int AGE_LIMIT   = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_INPUTS-1:0]        req_valid,
    input  logic [NUM_INPUTS*DEST_W-1:0] req_dest,
    input  logic [NUM_INPUTS*4-1:0]      req_prio,
    input  logic [NUM_INPUTS-1:0]        req_last,
    input  logic [NUM_OUTPUTS-1:0]       out_ready,
    output logic [NUM_OUTPUTS-1:0]       grant_valid,
    output logic [NUM_OUTPUTS*IN_W-1:0]  grant_sel,
    output logic [NUM_INPUTS-1:0]        in_grant
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t           state_q  [NUM_OUTPUTS];
    state_t           state_d  [NUM_OUTPUTS];
    logic [IN_W-1:0]  sel_q    [NUM_OUTPUTS];
    logic [IN_W-1:0]  rr_ptr_q [NUM_OUTPUTS];
    logic [IN_W-1:0]  win_idx  [NUM_OUTPUTS];
    logic [4:0]       eff_prio [NUM_INPUTS];
    logic [NUM_OUTPUTS-1:0] win_found;
    logic [NUM_OUTPUTS-1:0] release_now;

    if (AGE_LIMIT < 1 || AGE_LIMIT > 15) begin : g_age_limit_check
        $error("AGE_LIMIT must lie within 1..15");
    end

`ifdef XBAR_SCHED_AGING_EN
    logic [3:0]            wait_cnt_q [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] grant_now;

    always_comb begin
        grant_now = '0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            if (state_q[o] == IDLE && win_found[o]) begin
                grant_now[win_idx[o]] = 1'b1;
            end
        end
    end

    // Counter clears at the same edge the input is granted, so a winner never carries age into its next request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (!req_valid[i] || in_grant[i] || grant_now[i]) begin
                    wait_cnt_q[i] <= '0;
                end else if (wait_cnt_q[i] < 4'(AGE_LIMIT)) begin
                    wait_cnt_q[i] <= wait_cnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            eff_prio[i] = (wait_cnt_q[i] >= 4'(AGE_LIMIT)) ? 5'd16 : {1'b0, req_prio[i*4 +: 4]};
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            eff_prio[i] = {1'b0, req_prio[i*4 +: 4]};
        end
    end
`endif

    // Scan upward from the round-robin pointer; a strict compare keeps the first index among equal priorities.
    always_comb begin
        logic [IN_W-1:0] idx;
        logic [4:0]      best;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            win_found[o] = 1'b0;
            win_idx[o]   = '0;
            best         = '0;
            for (int k = 0; k < NUM_INPUTS; k++) begin
                idx = rr_ptr_q[o] + IN_W'(k);
                if (req_valid[idx] && !in_grant[idx] &&
                    req_dest[int'(idx)*DEST_W +: DEST_W] == DEST_W'(o) &&
                    (!win_found[o] || eff_prio[idx] > best)) begin
                    win_found[o] = 1'b1;
                    win_idx[o]   = idx;
                    best         = eff_prio[idx];
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            release_now[o] = (state_q[o] == HOLD) && req_valid[sel_q[o]] &&
                             out_ready[o] && req_last[sel_q[o]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int o = 0; o < NUM_OUTPUTS; o++) begin
                state_q[o]  <= IDLE;
                sel_q[o]    <= '0;
                rr_ptr_q[o] <= '0;
            end
        end else begin
            for (int o = 0; o < NUM_OUTPUTS; o++) begin
                state_q[o] <= state_d[o];
                if (state_q[o] == IDLE && win_found[o]) begin
                    sel_q[o]    <= win_idx[o];
                    rr_ptr_q[o] <= win_idx[o] + IN_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            state_d[o] = state_q[o];
            case (state_q[o])
                IDLE:    if (win_found[o])   state_d[o] = HOLD;
                HOLD:    if (release_now[o]) state_d[o] = IDLE;
                default: state_d[o] = IDLE;
            endcase
        end
    end

    always_comb begin
        in_grant = '0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            grant_valid[o]               = (state_q[o] == HOLD);
            grant_sel[o*IN_W +: IN_W]    = sel_q[o];
            if (state_q[o] == HOLD) begin
                in_grant[sel_q[o]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xbar_grant_scheduler.sv
// Directed self-checking bench for xbar_grant_scheduler (8x8); the aging scenario follows XBAR_SCHED_AGING_EN.
module tb_xbar_grant_scheduler;

    logic        clk;
    logic        rst_n;
    logic [7:0]  req_valid;
    logic [23:0] req_dest;
    logic [31:0] req_prio;
    logic [7:0]  req_last;
    logic [7:0]  out_ready;
    logic [7:0]  grant_valid;
    logic [23:0] grant_sel;
    logic [7:0]  in_grant;

    int checks;
    int failures;

    xbar_grant_scheduler #(
        .NUM_INPUTS (8),
        .NUM_OUTPUTS(8),
        .AGE_LIMIT  (12)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_dest   (req_dest),
        .req_prio   (req_prio),
        .req_last   (req_last),
        .out_ready  (out_ready),
        .grant_valid(grant_valid),
        .grant_sel  (grant_sel),
        .in_grant   (in_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int i, input logic valid, input int dest, input int prio, input logic last);
        req_valid[i]       = valid;
        req_dest[i*3 +: 3] = 3'(dest);
        req_prio[i*4 +: 4] = 4'(prio);
        req_last[i]        = last;
    endtask

    task automatic clear_requests();
        req_valid = '0;
        req_dest  = '0;
        req_prio  = '0;
        req_last  = '0;
        out_ready = '1;
    endtask

    task automatic reset_dut();
        clear_requests();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    function automatic logic [2:0] sel_of(input int o);
        return grant_sel[o*3 +: 3];
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        int exp_rr [4];
        int hold_cnt;
        int granted_at;
        logic seen7;

        checks   = 0;
        failures = 0;
        clear_requests();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        check_output("reset_grant_valid", 32'(grant_valid), 32'h00);
        check_output("reset_grant_sel", 32'(grant_sel), 32'h0);
        check_output("reset_in_grant", 32'(in_grant), 32'h00);
        rst_n = 1'b1;

        $display("[TB] priority arbitration on output 4");
        out_ready = '0;
        apply_stimulus(2, 1'b1, 4, 3, 1'b0);
        apply_stimulus(5, 1'b1, 4, 9, 1'b0);
        next_cycle();
        check_output("prio_grant_valid", 32'(grant_valid), 32'h10);
        check_output("prio_sel", 32'(sel_of(4)), 32'd5);
        check_output("prio_in_grant", 32'(in_grant), 32'h20);
        next_cycle();
        check_output("prio_stall_hold", 32'(grant_valid), 32'h10);
        out_ready[4] = 1'b1;
        apply_stimulus(5, 1'b1, 4, 9, 1'b1);
        next_cycle();
        check_output("prio_release_valid", 32'(grant_valid), 32'h00);
        check_output("prio_release_in_grant", 32'(in_grant), 32'h00);
        apply_stimulus(5, 1'b0, 0, 0, 1'b0);
        next_cycle();
        check_output("prio_second_sel", 32'(sel_of(4)), 32'd2);
        check_output("prio_second_in_grant", 32'(in_grant), 32'h04);
        reset_dut();

        $display("[TB] reset asserted during a held packet");
        out_ready = '0;
        apply_stimulus(3, 1'b1, 0, 1, 1'b0);
        next_cycle();
        check_output("rst_pre_valid", 32'(grant_valid), 32'h01);
        check_output("rst_pre_sel", 32'(sel_of(0)), 32'd3);
        rst_n = 1'b0;
        next_cycle();
        check_output("rst_mid_valid", 32'(grant_valid), 32'h00);
        check_output("rst_mid_in_grant", 32'(in_grant), 32'h00);
        check_output("rst_mid_sel", 32'(grant_sel), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) apply_stimulus(i, 1'b1, 0, 5, 1'b0);
        next_cycle();
        check_output("rst_rr_sel", 32'(sel_of(0)), 32'd0);
        check_output("rst_rr_in_grant", 32'(in_grant), 32'h01);
        reset_dut();

        $display("[TB] round-robin on output 2");
        exp_rr = '{1, 3, 6, 1};
        apply_stimulus(1, 1'b1, 2, 7, 1'b1);
        apply_stimulus(3, 1'b1, 2, 7, 1'b1);
        apply_stimulus(6, 1'b1, 2, 7, 1'b1);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            check_output("rr_grant_valid", 32'(grant_valid), 32'h04);
            check_output("rr_sel", 32'(sel_of(2)), 32'(exp_rr[k]));
            check_output("rr_in_grant", 32'(in_grant), 32'(1) << exp_rr[k]);
            if (k < 3) begin
                next_cycle();
                check_output("rr_bubble", 32'(grant_valid), 32'h00);
            end
        end
        reset_dut();

        $display("[TB] hold with stall on output 7");
        apply_stimulus(0, 1'b1, 7, 2, 1'b0);
        next_cycle();
        for (int c = 1; c <= 7; c++) begin
            check_output("stall_hold_valid", 32'(grant_valid), 32'h80);
            check_output("stall_hold_in_grant", 32'(in_grant), 32'h01);
            if (c == 1) apply_stimulus(4, 1'b1, 7, 15, 1'b0);
            out_ready[7] = !(c >= 2 && c <= 4);
            if (c == 7) apply_stimulus(0, 1'b1, 7, 2, 1'b1);
            next_cycle();
        end
        check_output("stall_release_valid", 32'(grant_valid), 32'h00);
        check_output("stall_release_in_grant", 32'(in_grant), 32'h00);
        apply_stimulus(0, 1'b0, 0, 0, 1'b0);
        next_cycle();
        check_output("stall_next_sel", 32'(sel_of(7)), 32'd4);
        check_output("stall_next_in_grant", 32'(in_grant), 32'h10);
        reset_dut();

        $display("[TB] parallel grants on outputs 3 and 5");
        apply_stimulus(0, 1'b1, 3, 4, 1'b0);
        apply_stimulus(1, 1'b1, 3, 4, 1'b0);
        apply_stimulus(2, 1'b1, 5, 4, 1'b0);
        next_cycle();
        check_output("par_grant_valid", 32'(grant_valid), 32'h28);
        check_output("par_sel3", 32'(sel_of(3)), 32'd0);
        check_output("par_sel5", 32'(sel_of(5)), 32'd2);
        check_output("par_in_grant", 32'(in_grant), 32'h05);
        next_cycle();
        apply_stimulus(0, 1'b1, 3, 4, 1'b1);
        next_cycle();
        check_output("par_bubble_valid", 32'(grant_valid), 32'h20);
        apply_stimulus(0, 1'b0, 0, 0, 1'b0);
        next_cycle();
        check_output("par_regrant_sel3", 32'(sel_of(3)), 32'd1);
        check_output("par_regrant_valid", 32'(grant_valid), 32'h28);
        check_output("par_regrant_in_grant", 32'(in_grant), 32'h06);
        reset_dut();

        $display("[TB] low-priority input 7 competing on output 1");
        apply_stimulus(7, 1'b1, 1, 0, 1'b1);
        apply_stimulus(0, 1'b1, 1, 15, 1'b1);
        apply_stimulus(1, 1'b1, 1, 15, 1'b1);
`ifdef XBAR_SCHED_AGING_EN
        granted_at = 0;
        for (int n = 1; n <= 20; n++) begin
            next_cycle();
            if (granted_at == 0 && in_grant[7]) granted_at = n;
        end
        check_output("aging_granted_in_time", 32'(granted_at >= 1 && granted_at <= 15), 32'd1);
`else
        seen7    = 1'b0;
        hold_cnt = 0;
        for (int n = 1; n <= 200; n++) begin
            next_cycle();
            seen7 = seen7 | in_grant[7];
            if (grant_valid[1]) hold_cnt++;
        end
        check_output("starve_input7_never", 32'(seen7), 32'd0);
        check_output("starve_output1_busy", 32'(hold_cnt), 32'd100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xbar_grant_scheduler.md
# xbar_grant_scheduler

- Per-output scheduler that decides which input owns each output port of the 8x8 packet crossbar and holds that connection until the packet's last beat is accepted.
- Sits between the requesting input ports and the crossbar datapath.
- Registered `grant_sel`/`grant_valid` per output drive the crossbar mux selects; `in_grant` tells each input it may stream.
- Arbitration is by 4-bit priority, with a round-robin tie-break per output and optional starvation aging.

## Interface
- `NUM_INPUTS`, 8: requesting ports; power of two, 2..16.
- `NUM_OUTPUTS`, 8: output ports; power of two, 2..16.
- `IN_W`, $clog2(NUM_INPUTS): width of an input index.
- `DEST_W`, $clog2(NUM_OUTPUTS): width of a destination index.
- `AGE_LIMIT`, 12: wait cycles before an input is promoted (1..15).
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  synchronous active-low reset, sampled on `clk` rising edge.
- `req_valid`  in  NUM_INPUTS  input i has a beat pending.
- `req_dest`  in  NUM_INPUTS*DEST_W  destination output of input i, field i at [i*DEST_W +: DEST_W].
- `req_prio`  in  NUM_INPUTS*4  priority of input i, 0 lowest, 15 highest.
- `req_last`  in  NUM_INPUTS  the pending beat of input i is the last of its packet.
- `out_ready`  in  NUM_OUTPUTS  output o accepts a beat this cycle.
- `grant_valid`  out  NUM_OUTPUTS  output o is connected to an input (registered).
- `grant_sel`  out  NUM_OUTPUTS*IN_W  connected input index for output o (registered).
- `in_grant`  out  NUM_INPUTS  input i currently owns some output (registered, at most one bit per input).

## Operation
- Each output has a two-state FSM.
  - IDLE: `grant_valid[o]`=0; arbitrate every cycle.
  - HOLD: `grant_valid[o]`=1; the winner is locked.
- Eligibility: input i is eligible for output o when `req_valid[i]`=1, `req_dest[i]`=o and `in_grant[i]`=0. Priority 0 is eligible.
- Effective priority is 5 bits: {1'b0, `req_prio[i]`}, or 16 when aged (see Configuration).
- The winner is the maximum effective priority. On a tie, pick the first index scanning upward from `rr_ptr[o]` with wrap.
- On grant:
  - FSM goes IDLE→HOLD.
  - `grant_sel[o]`=winner, `in_grant[winner]`=1.
  - `rr_ptr[o]`=(winner+1) mod NUM_INPUTS.
- Beat transfer on output o: `grant_valid[o]` & `req_valid[grant_sel[o]]` & `out_ready[o]`.
- HOLD→IDLE on a transfer with `req_last[grant_sel[o]]`=1. At the same edge, `grant_valid[o]` and the owner's `in_grant` go to 0.
- In HOLD, the owner's `req_dest`/`req_prio` are ignored. Changing `req_dest` mid-packet is a protocol violation; the output stays locked until the last beat.
- Simultaneous events:
  - One input is eligible for only one output, so no input is ever double-granted.
  - A release and a new grant on different outputs in the same cycle are independent.
- Reset values: `grant_valid`=0, `grant_sel`=0, `in_grant`=0, all FSMs IDLE, all `rr_ptr`=0, all age counters 0.
- Reset asserted mid-packet drops every connection at that edge with no drain.

## Timing
- Arbitration is combinational in the IDLE cycle; the grant is registered.
- Request first eligible in cycle t → `grant_valid[o]`=1 in t+1. The first beat can transfer in t+1.
- Last beat accepted in cycle t → `grant_valid[o]`=0 in t+1. The earliest next grant on that output is in t+2 (one bubble cycle per packet).
- `out_ready` low stalls transfers only; the grant is held indefinitely.
- A single-beat packet occupies an output for 2 cycles: grant plus bubble.

## Configuration
- `XBAR_SCHED_AGING_EN` defined:
  - Each input has a 4-bit `wait_cnt`. It increments each cycle `req_valid[i]`=1 and `in_grant[i]`=0, saturates at `AGE_LIMIT`, and clears when `in_grant[i]` rises or `req_valid[i]`=0.
  - `wait_cnt`≥`AGE_LIMIT` gives effective priority 16.
  - Among aged inputs, the round-robin tie-break applies.
- `XBAR_SCHED_AGING_EN` undefined: no counters; effective priority equals `req_prio`, so low priorities can starve.

## Test plan
- Reset: drive `rst_n`=0 during a HOLD.
  - Next edge: `grant_valid`=0, `in_grant`=0.
  - After release, inputs 0..7 all valid to output 0 with equal priority → `grant_sel[0]`=0 at the first grant.
- Priority: inputs 2 (prio 3) and 5 (prio 9) request output 4 in cycle t → `grant_valid[4]`=1, `grant_sel[4]`=5 and `in_grant`=8'b0010_0000 in t+1.
- Round-robin: inputs 1, 3 and 6 send back-to-back 1-beat packets to output 2 at equal priority with `out_ready`=1.
  - Grant order 1, 3, 6, 1.
  - Grants spaced 2 cycles apart.
- Hold/stall: a 4-beat packet from input 0 to output 7, `out_ready[7]` low for 3 cycles mid-packet.
  - Grant held throughout.
  - Release exactly one cycle after the 4th transfer.
  - Input 4 (prio 15) requesting output 7 meanwhile is not granted until the bubble cycle.
- Parallel: inputs 0→3, 1→3, 2→5 requested in the same cycle.
  - Outputs 3 and 5 both granted in t+1 (`grant_sel`=0 and 2).
  - Input 1 is granted on output 3 after input 0's last beat plus one bubble.
- Aging (`XBAR_SCHED_AGING_EN`, `AGE_LIMIT`=12): input 7 (prio 0) is continuously valid to output 1; inputs 0 and 1 (prio 15) continuously send 1-beat packets there.
  - Input 7 is granted no later than its 13th waiting cycle plus one packet slot.
  - Without the macro, input 7 is never granted over 200 cycles.
